// File: rtl/idli_pc_ctl_m.sv
// rtl/idli_pc_ctl_m.sv - slice sequencer for the nibble-serial program counter
// Aligns increment/branch operations to slice 0 and drives the PC's inc/load controls.
module idli_pc_ctl_m #(
  parameter int PC_W  = 16,
  parameter int SQI_W = 4,
  localparam int NS     = PC_W / SQI_W,
  localparam int SLOT_W = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic              i_pcc_gck,
  input  logic              i_pcc_rst,
  input  logic              i_pcc_inc_req,
  input  logic              i_pcc_br_req,
  input  logic [PC_W-1:0]   i_pcc_br_tgt,
  input  logic              i_pcc_stall,
  output logic [SLOT_W-1:0] o_pcc_slot,
  output logic              o_pcc_inc,
  output logic              o_pcc_ld,
  output logic [SQI_W-1:0]  o_pcc_ld_data,
  output logic              o_pcc_inc_ack,
  output logic              o_pcc_br_ack,
  output logic              o_pcc_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INC  = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [SLOT_W-1:0] r_slot;
  logic [SLOT_W-1:0] w_slot_nxt;
  logic [PC_W-1:0]   r_tgt;
  logic [PC_W-1:0]   w_tgt_nxt;
  // Set when a branch absorbed a simultaneous increment; that increment is acked with the branch.
  logic              r_inc_drop;
  logic              w_inc_drop_nxt;
  logic              w_last;
  logic              w_inc_avail;
  logic              w_br_avail;

  assign w_last     = (r_slot == SLOT_W'(NS - 1));
  assign w_slot_nxt = w_last ? '0 : r_slot + 1'b1;

  always_ff @(posedge i_pcc_gck) begin
    if (i_pcc_rst) begin
      r_slot     <= '0;
      r_state    <= ST_IDLE;
      r_tgt      <= '0;
      r_inc_drop <= 1'b0;
    end else begin
      r_slot     <= w_slot_nxt;
      r_state    <= w_state_nxt;
      r_tgt      <= w_tgt_nxt;
      r_inc_drop <= w_inc_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tgt_nxt      = r_tgt;
    w_inc_drop_nxt = r_inc_drop;
    w_inc_avail    = i_pcc_inc_req;
    w_br_avail     = i_pcc_br_req;

    // A request being acked this cycle must not restart an operation.
    case (r_state)
      ST_INC:  w_inc_avail = 1'b0;
      ST_LOAD: begin
        w_br_avail = 1'b0;
        if (r_inc_drop) w_inc_avail = 1'b0;
      end
      default: ;
    endcase

    if (w_last) begin
      w_state_nxt    = ST_IDLE;
      w_inc_drop_nxt = 1'b0;
      if (!i_pcc_stall) begin
        if (w_br_avail) begin
          w_state_nxt    = ST_LOAD;
          w_tgt_nxt      = i_pcc_br_tgt;
          w_inc_drop_nxt = w_inc_avail;
        end else if (w_inc_avail) begin
          w_state_nxt = ST_INC;
        end
      end
    end
  end

  assign o_pcc_slot    = r_slot;
  assign o_pcc_inc     = (r_state == ST_INC);
  assign o_pcc_ld      = (r_state == ST_LOAD);
  assign o_pcc_ld_data = (r_state == ST_LOAD) ? r_tgt[r_slot*SQI_W +: SQI_W] : '0;
  assign o_pcc_inc_ack = w_last && ((r_state == ST_INC) || ((r_state == ST_LOAD) && r_inc_drop));
  assign o_pcc_br_ack  = w_last && (r_state == ST_LOAD);
  assign o_pcc_busy    = (r_state != ST_IDLE);

endmodule

// File: doc/idli_pc_ctl_m.md
Name: idli_pc_ctl_m

Overview:
Sequencer for the nibble-serial 16b program counter. The PC rotates 4b per cycle, so one full update spans 4 cycles aligned to slice 0.
This block tracks the slice position and arbitrates increment and branch requests from the execute/fetch logic. It starts each operation on a slice-0 boundary and drives the PC's per-cycle increment enable or the serial load data. It sits between the control unit and the PC datapath, which it sequences exclusively.

Parameters:
PC_W, 16, PC width in bits; must be a multiple of SQI_W.
SQI_W, 4, bits of PC handled per cycle (SQI data width).
(Slices per update NS = PC_W/SQI_W = 4; slice counter width = log2(NS) = 2.)

Ports:
i_pcc_gck  input  1  clock; one clock domain only.
i_pcc_rst  input  1  reset, synchronous, active-high.
i_pcc_inc_req  input  1  request PC+1; level, held until o_pcc_inc_ack.
i_pcc_br_req  input  1  request PC load (branch); level, held until o_pcc_br_ack.
i_pcc_br_tgt  input  PC_W  branch target; stable while i_pcc_br_req high.
i_pcc_stall  input  1  blocks starting new operations.
o_pcc_slot  output  2  current PC slice index (0 = bits 3:0 present at PC output).
o_pcc_inc  output  1  increment enable to PC datapath.
o_pcc_ld  output  1  load enable to PC datapath (replace slice with o_pcc_ld_data).
o_pcc_ld_data  output  SQI_W  target nibble for current slice.
o_pcc_inc_ack  output  1  one-cycle pulse: increment request consumed.
o_pcc_br_ack  output  1  one-cycle pulse: branch request consumed.
o_pcc_busy  output  1  operation in progress.

Behaviour:
- Reset (sync, i_pcc_rst=1 at posedge): slot_q=0, state=IDLE, tgt_q=0.
- Reset outputs: o_pcc_inc, o_pcc_ld, both acks and o_pcc_busy are 0; o_pcc_ld_data is 0.
- PC datapath reset must be asserted in the same cycles, so slice alignment holds.
- slot_q: free-running, increments every cycle and wraps 3->0. It never stalls. o_pcc_slot = slot_q.
- States: IDLE, INC, LOAD.
- IDLE: sample requests only when slot_q==3 and i_pcc_stall==0.
  - br_req=1 -> LOAD and capture tgt_q <= i_pcc_br_tgt.
  - else inc_req=1 -> INC.
  - else stay in IDLE.
  - Requests arriving at slot 0..2 wait for the next slot 3 (start latency 1-4 cycles).
- INC: o_pcc_inc=1 for exactly 4 cycles, slots 0..3. o_pcc_inc_ack=1 in the slot-3 cycle.
- LOAD: o_pcc_ld=1 for slots 0..3, with o_pcc_ld_data = tgt_q[slot_q*SQI_W +: SQI_W]. o_pcc_br_ack=1 in the slot-3 cycle.
- Outputs are combinational from state_q/slot_q/tgt_q. o_pcc_inc and o_pcc_ld are never both 1.
- o_pcc_busy = (state != IDLE).
- Simultaneous requests at sampling: branch wins.
  - Both acks pulse together at the end of LOAD.
  - The increment is dropped, because the redirect supersedes it.
- End of operation (slot 3): the request being acked in that cycle is excluded from sampling. The other request is sampled normally (subject to stall), giving back-to-back operations.
  - Example: in INC with br_req pending -> LOAD next cycle.
  - A new request of the same type needs a fresh assertion after ack, so it waits one full rotation minimum.
- i_pcc_stall: only gates the IDLE->op and op->op transitions at slot 3. It never aborts an operation in progress.
- Reset mid-operation: abort immediately to IDLE, with no ack. The PC returns to 0 by its own reset, and requesters must re-issue.
- Request dropped before ack: protocol violation. The bench asserts on it; RTL behaviour is undefined.

Test Plan:
- Reset, inc_req=1 at slot 1 -> o_pcc_inc=1 for 4 cycles starting at next slot 0. inc_ack at slot 3. PC reads 0x0001.
- PC=0x0001, br_req with tgt=0xBEEF -> o_pcc_ld=1 slots 0..3, ld_data 0xF,0xE,0xE,0xB. br_ack at slot 3. PC=0xBEEF.
- inc_req and br_req (tgt=0x1234) together at slot 3 -> LOAD only; o_pcc_inc stays 0. Both acks pulse in the same cycle. PC=0x1234.
- PC=0x00FF, inc in progress with br_req (tgt=0x0800) raised at slot 2 -> INC completes (PC=0x0100), LOAD starts the next cycle with no idle gap, and PC=0x0800 after 4 more cycles.
- stall=1 with inc_req pending across 3 slot-3 boundaries -> no inc and busy=0. Stall drops at slot 1 -> INC starts at the following slot 0.
- i_pcc_rst=1 at slot 2 of LOAD -> next cycle state IDLE, slot 0, no br_ack. Re-issued branch completes normally.
